// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulState_t;

  // The counter must hold INPUT_SIZE itself, hence the +1.
  function automatic int cntWidth(input int inputSize);
    return $clog2(inputSize + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// master = requester (drives operands), slave = multiplier.
interface seq_multiplier_if #(
  parameter int INPUT_SIZE = 10
);

  logic                      start;
  logic [INPUT_SIZE-1:0]     A;
  logic [INPUT_SIZE-1:0]     B;
  logic [2*INPUT_SIZE-1:0]   P;
  logic                      busy;
  logic                      done;

  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);

endinterface

// File: rtl/seq_multiplier_shift_add_step.sv
// One combinational shift-and-add iteration: conditionally adds the
// multiplicand into the accumulator, then shifts multiplicand left and
// multiplier right. Also flags when the shifted multiplier has run out
// of set bits, which lets the controller stop early.
module shift_add_step #(
  parameter int INPUT_SIZE = 10
) (
  input  logic [2*INPUT_SIZE-1:0] mcand,
  input  logic [INPUT_SIZE-1:0]   mplr,
  input  logic [2*INPUT_SIZE-1:0] acc,
  output logic [2*INPUT_SIZE-1:0] mcandNext,
  output logic [INPUT_SIZE-1:0]   mplrNext,
  output logic [2*INPUT_SIZE-1:0] accNext,
  output logic                    mplrNextZero
);

  // Add-if-bit-set followed by the shifts; the add wraps at the product
  // width, which unsigned operands can never exceed.
  always_comb begin
    accNext      = acc + (mplr[0] ? mcand : '0);
    mcandNext    = mcand << 1;
    mplrNext     = mplr >> 1;
    mplrNextZero = (mplrNext == '0);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per clock.
// Handshake: start is accepted in IDLE or DONE; busy is high in RUN; done
// pulses for one cycle and P holds the last product until the next one.
// Optional build macro SEQ_MULTIPLIER_EARLY_TERM_EN: finish as soon as the
// remaining multiplier bits are all zero (same product, shorter latency).
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int INPUT_SIZE = 10
) (
  input logic              clk,
  input logic              rst,
  seq_multiplier_if.slave  bus
);

  localparam int CntW = cntWidth(INPUT_SIZE);

  mulState_t state;
  mulState_t stateNext;

  logic [2*INPUT_SIZE-1:0] mcand;
  logic [INPUT_SIZE-1:0]   mplr;
  logic [2*INPUT_SIZE-1:0] acc;
  logic [CntW-1:0]         cnt;
  logic [2*INPUT_SIZE-1:0] pReg;

  logic [2*INPUT_SIZE-1:0] stepMcand;
  logic [INPUT_SIZE-1:0]   stepMplr;
  logic [2*INPUT_SIZE-1:0] stepAcc;

  logic load;
  logic finish;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  logic stepMplrZero;

  shift_add_step #(.INPUT_SIZE(INPUT_SIZE)) uStep (
    .mcand        (mcand),
    .mplr         (mplr),
    .acc          (acc),
    .mcandNext    (stepMcand),
    .mplrNext     (stepMplr),
    .accNext      (stepAcc),
    .mplrNextZero (stepMplrZero)
  );
`else
  shift_add_step #(.INPUT_SIZE(INPUT_SIZE)) uStep (
    .mcand        (mcand),
    .mplr         (mplr),
    .acc          (acc),
    .mcandNext    (stepMcand),
    .mplrNext     (stepMplr),
    .accNext      (stepAcc),
    .mplrNextZero ()
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic plus the load/finish strobes used by the datapath.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        finish = (cnt == CntW'(1)) || stepMplrZero;
`else
        finish = (cnt == CntW'(1));
`endif
        if (finish) stateNext = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath registers: capture operands on accept, step while running,
  // and commit the final accumulator to P only on the finishing step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      pReg  <= '0;
    end else if (load) begin
      mcand <= {{INPUT_SIZE{1'b0}}, bus.A};
      mplr  <= bus.B;
      acc   <= '0;
      cnt   <= CntW'(INPUT_SIZE);
    end else if (state == RUN) begin
      mcand <= stepMcand;
      mplr  <= stepMplr;
      acc   <= stepAcc;
      cnt   <= cnt - CntW'(1);
      if (finish) pReg <= stepAcc;
    end
  end

  assign bus.P    = pReg;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier (INPUT_SIZE=10). Expected latencies
// follow SEQ_MULTIPLIER_EARLY_TERM_EN when the bench is built with it.
module tb_seq_multiplier;

  localparam int N = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seq_multiplier_if #(.INPUT_SIZE(N)) bus ();

  seq_multiplier #(.INPUT_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock; stimulus and sampling both on the falling edge.
  always #5 clk = ~clk;

  // Hand-derived latency rule for the build under test.
  function automatic int expLatency(input logic [N-1:0] b);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    int hi = 0;
    for (int i = 0; i < N; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    return N;
`endif
  endfunction

  // Drive one start cycle; returns at the falling edge right after acceptance.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges after acceptance until done and busy samples along the way.
  task automatic waitDone(output int edges, output int busyCycles);
    edges = 0;
    busyCycles = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      if (bus.busy === 1'b1) busyCycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.P !== 20'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: P=%0d busy=%b done=%b, required P=0 busy=0 done=0",
                 i, bus.P, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_basic;
    int edges, busyCycles;
    issue(10'd37, 10'd25);
    waitDone(edges, busyCycles);
    checks++;
    if (edges !== expLatency(10'd25)) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges, required %0d", edges, expLatency(10'd25));
    end
    checks++;
    if (busyCycles !== expLatency(10'd25)) begin
      errors++;
      $display("[TB] FAIL basic_busy: busy for %0d cycles, required %0d", busyCycles, expLatency(10'd25));
    end
    checks++;
    if (bus.P !== 20'd925) begin
      errors++;
      $display("[TB] FAIL basic_product: P=%0d, required 925", bus.P);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.P !== 20'd925) begin
      errors++;
      $display("[TB] FAIL basic_hold: done=%b P=%0d, required done=0 P=925", bus.done, bus.P);
    end
  endtask

  task automatic test_back_to_back;
    int edges, busyCycles;
    issue(10'd1023, 10'd1023);
    waitDone(edges, busyCycles);
    checks++;
    if (edges !== N || bus.P !== 20'hFF801) begin
      errors++;
      $display("[TB] FAIL max_operands: edges=%0d P=%0d, required edges=%0d P=1046529", edges, bus.P, N);
    end
    // Still in the DONE cycle: issue the next operation immediately.
    bus.start = 1'b1;
    bus.A = 10'd0;
    bus.B = 10'd500;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.P !== 20'hFF801) begin
      errors++;
      $display("[TB] FAIL b2b_accept: busy=%b P=%0d, required busy=1 P=1046529", bus.busy, bus.P);
    end
    waitDone(edges, busyCycles);
    checks++;
    if (edges !== expLatency(10'd500) || bus.P !== 20'd0) begin
      errors++;
      $display("[TB] FAIL b2b_product: edges=%0d P=%0d, required edges=%0d P=0",
               edges, bus.P, expLatency(10'd500));
    end
    @(negedge clk);
  endtask

  task automatic test_zero_multiplier;
    int edges, busyCycles;
    issue(10'd300, 10'd0);
    waitDone(edges, busyCycles);
    checks++;
    if (edges !== expLatency(10'd0) || bus.P !== 20'd0) begin
      errors++;
      $display("[TB] FAIL zero_mplr: edges=%0d P=%0d, required edges=%0d P=0",
               edges, bus.P, expLatency(10'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int edges, busyCycles, extraDone;
    issue(10'd7, 10'd9);
    // Second request while running, with different operands.
    bus.start = 1'b1;
    bus.A = 10'd5;
    bus.B = 10'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 10'd0;
    bus.B = 10'd0;
    waitDone(edges, busyCycles);
    checks++;
    if (edges !== expLatency(10'd9) - 1 || bus.P !== 20'd63) begin
      errors++;
      $display("[TB] FAIL ignore_start: edges=%0d P=%0d, required edges=%0d P=63",
               edges, bus.P, expLatency(10'd9) - 1);
    end
    extraDone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone !== 0 || bus.P !== 20'd63) begin
      errors++;
      $display("[TB] FAIL ignore_no_second: %0d busy/done cycles, P=%0d, required 0 and P=63",
               extraDone, bus.P);
    end
  endtask

  task automatic test_midrun_reset;
    int extraDone;
    issue(10'd100, 10'd100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 20'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%b done=%b P=%0d, required 0 0 0",
               bus.busy, bus.done, bus.P);
    end
    rst = 1'b0;
    extraDone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone !== 0 || bus.P !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: %0d busy/done cycles, P=%0d, required 0 and P=0",
               extraDone, bus.P);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_multiplier();
    test_start_ignored();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
